// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared definitions for the ID-stage hazard unit: branch codes, pending-load entry, source matcher.
package pipeline_hazard_unit_pkg;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  // Widest register address the pending entry can hold; narrower addresses are zero-extended.
  localparam int PEND_ADDR_W = 8;

  typedef struct packed {
    logic                   valid;
    logic [PEND_ADDR_W-1:0] addr;
  } pend_t;

  function automatic logic src_match(
    input logic [PEND_ADDR_W-1:0] addr,
    input logic [PEND_ADDR_W-1:0] rs,
    input logic [PEND_ADDR_W-1:0] rt,
    input logic                   uses_rs,
    input logic                   uses_rt
  );
    return (addr != '0) && ((uses_rs && (addr == rs)) || (uses_rt && (addr == rt)));
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Load-use / branch-operand hazard detection and branch flush for the ID stage, with perf counters.
// Hazard outputs are combinational (zero latency); counters update on the following clock.
module pipeline_hazard_unit
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] IF_ID_rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_rt,
  input  logic                  IF_ID_uses_rs,
  input  logic                  IF_ID_uses_rt,
  input  logic [REG_ADDR_W-1:0] ID_EX_rd,
  input  logic                  ID_EX_mem_read,
  input  logic                  ID_EX_reg_write,
  input  logic [1:0]            branch,
  input  logic                  equal,
  input  logic                  cnt_clr,
  output logic                  pc_write,
  output logic                  IF_ID_write,
  output logic                  mux_hz_unit,
  output logic                  flush,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  logic [PEND_ADDR_W-1:0] rd_x;
  logic [PEND_ADDR_W-1:0] rs_x;
  logic [PEND_ADDR_W-1:0] rt_x;
  logic                   ex_match;
  logic                   pipe_haz;
  logic                   load_haz;
  logic                   br_haz;
  logic                   stall_raw;
  logic                   taken;
  logic                   stall;

  assign rd_x = PEND_ADDR_W'(ID_EX_rd);
  assign rs_x = PEND_ADDR_W'(IF_ID_rs);
  assign rt_x = PEND_ADDR_W'(IF_ID_rt);

  assign ex_match = src_match(rd_x, rs_x, rt_x, IF_ID_uses_rs, IF_ID_uses_rt);

  // Loads keep shifting through the pipe during a stall because the injected bubble advances EX.
  generate
    if (LOAD_LAT > 1) begin : g_pipe
      localparam int DEPTH = LOAD_LAT - 1;
      pend_t            pend_q [DEPTH];
      pend_t            pend_d [DEPTH];
      logic [DEPTH-1:0] hit;

      always_comb begin
        pend_d[0] = '{valid: ID_EX_mem_read && (ID_EX_rd != '0), addr: rd_x};
        for (int k = 1; k < DEPTH; k++) begin
          pend_d[k] = pend_q[k-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < DEPTH; k++) pend_q[k] <= '0;
        end else begin
          for (int k = 0; k < DEPTH; k++) pend_q[k] <= pend_d[k];
        end
      end

      for (genvar k = 0; k < DEPTH; k++) begin : g_hit
        assign hit[k] = pend_q[k].valid &&
                        src_match(pend_q[k].addr, rs_x, rt_x, IF_ID_uses_rs, IF_ID_uses_rt);
      end

      assign pipe_haz = |hit;
    end else begin : g_no_pipe
      assign pipe_haz = 1'b0;
    end
  endgenerate

  assign load_haz  = (ID_EX_mem_read && ex_match) || pipe_haz;
  assign br_haz    = ((branch == BR_EQ) || (branch == BR_NE)) && ID_EX_reg_write && ex_match;
  assign stall_raw = load_haz || br_haz;

  assign taken = ((branch == BR_EQ) &&  equal) ||
                 ((branch == BR_NE) && !equal) ||
                  (branch == BR_JMP);

  // Reset forces the "free-running" output state regardless of what the pipeline presents.
  assign stall       = stall_raw && !rst;
  assign flush       = taken && !stall_raw && !rst;
  assign pc_write    = !stall;
  assign IF_ID_write = !stall;
  assign mux_hz_unit = !stall;

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .clr   (cnt_clr),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench: one single-bubble instance (LOAD_LAT=1, 16-bit counters) and one
// LOAD_LAT=3 instance with 4-bit counters share the same stimulus.
module tb_pipeline_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs, rt, rd;
  logic       urs, urt, mrd, rwr, eq, clr;
  logic [1:0] br;

  logic        pw1, iw1, mx1, fl1;
  logic [15:0] sc1, fc1;
  logic        pw3, iw3, mx3, fl3;
  logic [3:0]  sc3, fc3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_unit #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .IF_ID_rs(rs), .IF_ID_rt(rt), .IF_ID_uses_rs(urs), .IF_ID_uses_rt(urt),
    .ID_EX_rd(rd), .ID_EX_mem_read(mrd), .ID_EX_reg_write(rwr), .branch(br), .equal(eq),
    .cnt_clr(clr), .pc_write(pw1), .IF_ID_write(iw1), .mux_hz_unit(mx1), .flush(fl1),
    .stall_cnt(sc1), .flush_cnt(fc1)
  );

  pipeline_hazard_unit #(.REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .IF_ID_rs(rs), .IF_ID_rt(rt), .IF_ID_uses_rs(urs), .IF_ID_uses_rt(urt),
    .ID_EX_rd(rd), .ID_EX_mem_read(mrd), .ID_EX_reg_write(rwr), .branch(br), .equal(eq),
    .cnt_clr(clr), .pc_write(pw3), .IF_ID_write(iw3), .mux_hz_unit(mx3), .flush(fl3),
    .stall_cnt(sc3), .flush_cnt(fc3)
  );

  task automatic idle_inputs();
    rs = 5'd0; rt = 5'd0; rd = 5'd0;
    urs = 1'b0; urt = 1'b0; mrd = 1'b0; rwr = 1'b0; eq = 1'b0; clr = 1'b0;
    br = 2'b00;
  endtask

  task automatic set_load(input logic [4:0] r);
    idle_inputs();
    mrd = 1'b1; rwr = 1'b1; rd = r; rs = r; urs = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle_inputs();
    end
  endtask

  task automatic clear_counters();
    @(negedge clk); idle_inputs(); clr = 1'b1;
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_load(5'd8); br = 2'b11; eq = 1'b1;
    #1;
    checks++; if (pw1 !== 1'b1 || iw1 !== 1'b1 || mx1 !== 1'b1) begin errors++; $display("FAIL reset_ctrl_lat1 got=%b%b%b exp=111", pw1, iw1, mx1); end
    checks++; if (pw3 !== 1'b1 || mx3 !== 1'b1) begin errors++; $display("FAIL reset_ctrl_lat3 got=%b%b exp=11", pw3, mx3); end
    checks++; if (fl1 !== 1'b0 || fl3 !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b%b exp=00", fl1, fl3); end
    checks++; if (sc1 !== 16'd0 || fc1 !== 16'd0 || sc3 !== 4'd0) begin errors++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0", sc1, fc1, sc3); end
    @(negedge clk); rst = 1'b0; idle_inputs();
    idle_cycles(2);
  endtask

  task automatic test_load_use_lat1();
    clear_counters();
    set_load(5'd8); #1;
    checks++; if (pw1 !== 1'b0 || iw1 !== 1'b0 || mx1 !== 1'b0) begin errors++; $display("FAIL lat1_stall got=%b%b%b exp=000", pw1, iw1, mx1); end
    @(negedge clk); idle_inputs(); rs = 5'd8; urs = 1'b1; #1;
    checks++; if (pw1 !== 1'b1 || iw1 !== 1'b1 || mx1 !== 1'b1) begin errors++; $display("FAIL lat1_release got=%b%b%b exp=111", pw1, iw1, mx1); end
    checks++; if (sc1 !== 16'd1) begin errors++; $display("FAIL lat1_stall_cnt got=%0d exp=1", sc1); end
    idle_cycles(3);
  endtask

  task automatic test_load_use_lat3();
    clear_counters();
    set_load(5'd8); #1;
    checks++; if (pw3 !== 1'b0) begin errors++; $display("FAIL lat3_cycle0 got=%b exp=0", pw3); end
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk); idle_inputs(); rs = 5'd8; urs = 1'b1; #1;
      checks++; if (pw3 !== 1'b0 || iw3 !== 1'b0 || mx3 !== 1'b0) begin errors++; $display("FAIL lat3_cycle%0d got=%b%b%b exp=000", c, pw3, iw3, mx3); end
      if (c == 1) begin
        checks++; if (pw1 !== 1'b1) begin errors++; $display("FAIL lat1_no_pipe got=%b exp=1", pw1); end
      end
    end
    @(negedge clk); idle_inputs(); rs = 5'd8; urs = 1'b1; #1;
    checks++; if (pw3 !== 1'b1) begin errors++; $display("FAIL lat3_release got=%b exp=1", pw3); end
    checks++; if (sc3 !== 4'd3) begin errors++; $display("FAIL lat3_stall_cnt got=%0d exp=3", sc3); end
    idle_cycles(3);
  endtask

  task automatic test_no_hazard();
    @(negedge clk); idle_inputs(); mrd = 1'b1; rd = 5'd0; rt = 5'd0; urt = 1'b1; #1;
    checks++; if (pw1 !== 1'b1 || pw3 !== 1'b1) begin errors++; $display("FAIL r0_no_stall got=%b%b exp=11", pw1, pw3); end
    @(negedge clk); idle_inputs(); mrd = 1'b1; rd = 5'd9; rs = 5'd9; rt = 5'd9; #1;
    checks++; if (pw1 !== 1'b1 || pw3 !== 1'b1) begin errors++; $display("FAIL unused_src_no_stall got=%b%b exp=11", pw1, pw3); end
    @(negedge clk); idle_inputs(); rs = 5'd9; rt = 5'd9; #1;
    checks++; if (pw3 !== 1'b1) begin errors++; $display("FAIL unused_src_pipe got=%b exp=1", pw3); end
    idle_cycles(3);
  endtask

  task automatic test_branch_stall();
    clear_counters();
    idle_inputs(); br = 2'b01; eq = 1'b1; rwr = 1'b1; rd = 5'd5; rs = 5'd5; urs = 1'b1; #1;
    checks++; if (pw1 !== 1'b0 || fl1 !== 1'b0) begin errors++; $display("FAIL br_stall got pw=%b fl=%b exp pw=0 fl=0", pw1, fl1); end
    @(negedge clk); rwr = 1'b0; rd = 5'd0; #1;
    checks++; if (pw1 !== 1'b1 || fl1 !== 1'b1) begin errors++; $display("FAIL br_flush got pw=%b fl=%b exp pw=1 fl=1", pw1, fl1); end
    @(negedge clk); idle_inputs(); #1;
    checks++; if (fl1 !== 1'b0) begin errors++; $display("FAIL br_flush_one_cycle got=%b exp=0", fl1); end
    checks++; if (fc1 !== 16'd1 || sc1 !== 16'd1) begin errors++; $display("FAIL br_counts got flush=%0d stall=%0d exp 1/1", fc1, sc1); end
    idle_cycles(2);
  endtask

  task automatic test_jump_during_load();
    set_load(5'd8); br = 2'b11; #1;
    checks++; if (fl3 !== 1'b0 || pw3 !== 1'b0) begin errors++; $display("FAIL jmp_load_c0 got fl=%b pw=%b exp 0/0", fl3, pw3); end
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk); idle_inputs(); rs = 5'd8; urs = 1'b1; br = 2'b11; #1;
      checks++; if (fl3 !== 1'b0) begin errors++; $display("FAIL jmp_load_c%0d got=%b exp=0", c, fl3); end
    end
    @(negedge clk); #1;
    checks++; if (fl3 !== 1'b1 || pw3 !== 1'b1) begin errors++; $display("FAIL jmp_after_stall got fl=%b pw=%b exp 1/1", fl3, pw3); end
    @(negedge clk); idle_inputs(); br = 2'b11; rwr = 1'b1; rd = 5'd5; rs = 5'd5; urs = 1'b1; #1;
    checks++; if (fl1 !== 1'b1 || pw1 !== 1'b1) begin errors++; $display("FAIL jmp_no_br_haz got fl=%b pw=%b exp 1/1", fl1, pw1); end
    @(negedge clk); idle_inputs(); br = 2'b10; eq = 1'b1; #1;
    checks++; if (fl1 !== 1'b0 || fl3 !== 1'b0) begin errors++; $display("FAIL bne_equal got=%b%b exp=00", fl1, fl3); end
    @(negedge clk); eq = 1'b0; #1;
    checks++; if (fl1 !== 1'b1) begin errors++; $display("FAIL bne_notequal got=%b exp=1", fl1); end
    idle_cycles(3);
  endtask

  task automatic test_saturation();
    clear_counters();
    for (int i = 0; i < 19; i++) begin
      @(negedge clk); set_load(5'd8);
    end
    @(negedge clk); set_load(5'd8); #1;
    checks++; if (sc3 !== 4'hF) begin errors++; $display("FAIL sat_hold got=%0d exp=15", sc3); end
    checks++; if (sc1 !== 16'd19) begin errors++; $display("FAIL sat_wide got=%0d exp=19", sc1); end
    clr = 1'b1;
    @(negedge clk); idle_inputs(); #1;
    checks++; if (sc3 !== 4'd0 || sc1 !== 16'd0) begin errors++; $display("FAIL clr_priority got=%0d/%0d exp=0/0", sc3, sc1); end
    idle_cycles(3);
  endtask

  task automatic test_reset_mid_stall();
    set_load(5'd8);
    @(negedge clk); idle_inputs(); rs = 5'd8; urs = 1'b1; br = 2'b11; #1;
    checks++; if (pw3 !== 1'b0) begin errors++; $display("FAIL rst_pre_stall got=%b exp=0", pw3); end
    rst = 1'b1; #1;
    checks++; if (pw3 !== 1'b1 || iw3 !== 1'b1 || mx3 !== 1'b1 || fl3 !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got=%b%b%b%b exp=1110", pw3, iw3, mx3, fl3); end
    @(negedge clk); rst = 1'b0; br = 2'b00; #1;
    checks++; if (pw3 !== 1'b1) begin errors++; $display("FAIL rst_pipe_dropped got=%b exp=1", pw3); end
    checks++; if (sc3 !== 4'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", sc3); end
    idle_cycles(2);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_use_lat1();
    test_load_use_lat3();
    test_no_hazard();
    test_branch_stall();
    test_jump_during_load();
    test_saturation();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
- Parametrised successor to the pipeline's load-use hazard / branch-flush logic for the 5-stage MIPS core; sits beside the ID stage.
- Tracks in-flight loads for a configurable memory latency. Stalls branches whose ID-stage comparison needs an EX result that is not yet written.
- Produces a clean one-cycle-per-event flush and keeps saturating stall/flush performance counters.

Parameters:
- REG_ADDR_W, 5, register-address width.
- LOAD_LAT, 1, cycles after a load leaves EX before its data is forwardable (1 = classic single-bubble load-use). Legal range 1..4.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- IF_ID_rs  in  REG_ADDR_W  source register rs of the instruction in ID
- IF_ID_rt  in  REG_ADDR_W  source register rt of the instruction in ID
- IF_ID_uses_rs  in  1  ID instruction reads rs
- IF_ID_uses_rt  in  1  ID instruction reads rt
- ID_EX_rd  in  REG_ADDR_W  destination register of the instruction in EX
- ID_EX_mem_read  in  1  EX instruction is a load
- ID_EX_reg_write  in  1  EX instruction writes a register
- branch  in  2  00 none, 01 beq, 10 bne, 11 jump
- equal  in  1  ID-stage comparator result
- cnt_clr  in  1  synchronous clear of both counters
- pc_write  out  1  1 = PC may update
- IF_ID_write  out  1  1 = IF/ID may update
- mux_hz_unit  out  1  1 = pass control signals; 0 = inject bubble into EX
- flush  out  1  1 = squash the IF/ID contents
- stall_cnt  out  CNT_W  cycles stalled
- flush_cnt  out  CNT_W  flushes issued

Behaviour:
- Register 0 never causes a hazard. A source matches only if its uses_* bit is 1.
- Pending-load pipe:
  - LOAD_LAT-1 entries {valid, addr}.
  - Every clock: entry1 <= {ID_EX_mem_read & ID_EX_rd!=0, ID_EX_rd}; entry k <= entry k-1.
  - Entries are never frozen by a stall, because the bubble keeps EX advancing.
  - With LOAD_LAT=1 the pipe is absent.
- load_haz: ID_EX_mem_read and ID_EX_rd matches a used source, OR any valid pipe entry matches a used source.
- br_haz: branch in {01,10}, ID_EX_reg_write=1, ID_EX_rd!=0 and ID_EX_rd matches a used source. Jumps never cause br_haz.
- stall = load_haz | br_haz.
  - When stall: pc_write=0, IF_ID_write=0, mux_hz_unit=0.
  - Otherwise all three are 1.
- taken: (branch=01 & equal) | (branch=10 & !equal) | branch=11.
- flush = taken & !stall. A branch that is stalled does not flush; it is re-evaluated on the cycle the stall clears.
- All hazard outputs are combinational from the inputs and pipe state, with zero latency.
- Counters (registered):
  - stall_cnt increments on every cycle with stall=1.
  - flush_cnt increments on every cycle with flush=1.
  - Both saturate at all-ones with no wrap.
  - cnt_clr has priority over increment; the counter reads 0 on the next cycle.
- Reset:
  - While rst=1: pipe entries invalid, counters 0.
  - Outputs are forced to pc_write=1, IF_ID_write=1, mux_hz_unit=1, flush=0 regardless of inputs.
  - On deassertion, operation starts with an empty pipe.
  - A reset mid-stall drops every pending load.
- Simultaneous load_haz and taken: stall wins, flush=0.

Decomposition:
- Shared package holds:
  - branch-code constants BR_NONE=2'b00, BR_EQ=2'b01, BR_NE=2'b10, BR_JMP=2'b11;
  - the pending-entry struct {valid, addr}.
- One natural sub-module, hazard_sat_counter (CNT_W, inc, clr, count), instantiated twice.
- The pending pipe and compare logic stay inline using a generate block.

Test Plan:
1. LOAD_LAT=1: ID_EX_mem_read=1, ID_EX_rd=8, IF_ID_rs=8, uses_rs=1 -> exactly 1 cycle of pc_write=IF_ID_write=mux_hz_unit=0; stall_cnt=1.
2. LOAD_LAT=3: same load, then bubbles in EX -> stall held 3 consecutive cycles, released on the 4th; stall_cnt=3.
3. Load to register 0 with IF_ID_rt=0, uses_rt=1 -> no stall; load to 9 with uses_rs=uses_rt=0 -> no stall.
4. branch=01, equal=1, ID_EX_reg_write=1, ID_EX_rd=5=IF_ID_rs -> cycle 1: stall, flush=0. Cycle 2: EX holds the bubble, flush=1 for one cycle; flush_cnt=1.
5. branch=11 during an active load_haz -> flush=0 until the stall clears, then flush=1. branch=10 with equal=1 -> flush=0.
6. Force 2^CNT_W+3 stall cycles -> stall_cnt holds all-ones. Pulse cnt_clr -> 0 next cycle. Assert rst mid-LOAD_LAT=3 stall -> outputs at reset defaults immediately, no stall after release.
